hamming_encoder_8bit_stream: RTL

Streaming Hamming(12,8) SEC encoder: accepts data bytes on a valid/ready input and emits 12-bit codewords on a valid/ready output through an internal 2-entry buffer. It is the transmit-side counterpart of the team's 8-bit Hamming decoder and uses the same codeword layout: parity in bits [3:0], data in bits [11:4]. It also provides a one-shot error-injection port for link and decoder testing, and a delivered-codeword counter.

---
 rtl/hamming_encoder_8bit_stream.sv | 109 ++++++++++
 1 files changed

// File: rtl/hamming_encoder_8bit_stream.sv
// Streaming Hamming(12,8) SEC encoder with a 2-entry output buffer.
// It also has one-shot error injection and a count of delivered codewords.
module hamming_encoder_8bit_stream #(
    parameter int CNT_W = 16
) (
    input  logic             sys_clk,
    input  logic             rst,
    input  logic [7:0]       data_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [11:0]      code_out,
    output logic             code_inj,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             inj_en,
    input  logic [11:0]      inj_mask,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt
);

    // Codeword layout {d[7:0], p[3:0]} matches the receive-side decoder.
    function automatic logic [11:0] encode(input logic [7:0] d);
        logic [3:0] p;
        p[0] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6];
        p[1] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6];
        p[2] = d[1] ^ d[2] ^ d[3] ^ d[7];
        p[3] = d[4] ^ d[5] ^ d[6] ^ d[7];
        return {d, p};
    endfunction

    logic [1:0]  occ;
    logic [11:0] head_code;
    logic        head_inj;
    logic [11:0] tail_code;
    logic        tail_inj;
    logic [11:0] armed_mask;
    logic        accept;
    logic        pop;
    logic [11:0] word_next;

    assign in_ready  = (occ != 2'd2);
    assign out_valid = (occ != 2'd0);
    assign code_out  = head_code;
    assign code_inj  = head_inj;
    assign accept    = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // The armed mask is only consumed while pending, so a stale mask is harmless.
    assign word_next = encode(data_in) ^ (inj_pending ? armed_mask : 12'h000);

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            occ       <= 2'd0;
            head_code <= 12'h000;
            head_inj  <= 1'b0;
            tail_code <= 12'h000;
            tail_inj  <= 1'b0;
        end else begin
            unique case ({accept, pop})
                2'b10: begin
                    occ <= occ + 2'd1;
                    if (occ == 2'd0) begin
                        head_code <= word_next;
                        head_inj  <= inj_pending;
                    end else begin
                        tail_code <= word_next;
                        tail_inj  <= inj_pending;
                    end
                end
                2'b01: begin
                    occ       <= occ - 2'd1;
                    head_code <= tail_code;
                    head_inj  <= tail_inj;
                    tail_code <= 12'h000;
                    tail_inj  <= 1'b0;
                end
                2'b11: begin
                    // Only reachable at occupancy 1: the new word becomes head.
                    head_code <= word_next;
                    head_inj  <= inj_pending;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            inj_pending <= 1'b0;
            armed_mask  <= 12'h000;
        end else if (inj_en) begin
            inj_pending <= 1'b1;
            armed_mask  <= inj_mask;
        end else if (accept) begin
            inj_pending <= 1'b0;
            armed_mask  <= 12'h000;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

endmodule
